// File: rtl/muldiv_seq.sv
// Sequential 32-bit MUL / DIVU / REMU engine that borrows an external add/sub ALU.
// Latency: 33 cycles for MUL and non-zero divides, 1 cycle for divide-by-zero and reserved op.
// Backpressure: one operation in flight; req_ready only in IDLE, result held until resp_ready.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_s,
  input  logic [XLEN-1:0] alu_f
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;

  // Restoring-divide step: shift the next dividend bit into R and decide whether b fits.
  // The bit shifted out of R (div_c) means the partial remainder is >= 2^32 and so b always fits;
  // the ALU difference then wraps back to the correct 32-bit remainder.
  logic            div_c;
  logic [XLEN-1:0] div_t;
  logic            div_take;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  // Per-iteration divide datapath, derived purely from current state.
  always_comb begin
    div_c    = rem_q[XLEN-1];
    div_t    = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    div_take = div_c | (div_t >= b_q);
    rem_next = div_take ? alu_f : div_t;
    quo_next = {quo_q[XLEN-2:0], div_take};
  end

  // Drive the shared ALU only while iterating; park it at ADD 0+0 otherwise.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_s = ALU_ADD;
    if (state_q == S_BUSY) begin
      if (op_q == OP_MUL) begin
        alu_s = ALU_ADD;
        alu_a = acc_q;
        alu_b = mplier_q[0] ? mcand_q : '0;
      end else begin
        alu_s = ALU_SUB;
        alu_a = div_t;
        alu_b = b_q;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    b_d         = b_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    resp_data_d = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          b_d  = req_b;
          case (req_op)
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = req_a;
              mplier_d = req_b;
              cnt_d    = '0;
              state_d  = S_BUSY;
            end
            OP_DIVU, OP_REMU: begin
              if (req_b == '0) begin
                // Divide by zero: quotient saturates to all ones, remainder is the dividend.
                resp_data_d = (req_op == OP_DIVU) ? '1 : req_a;
                state_d     = S_DONE;
              end else begin
                rem_d   = '0;
                quo_d   = req_a;
                cnt_d   = '0;
                state_d = S_BUSY;
              end
            end
            default: begin
              resp_data_d = '0;
              state_d     = S_DONE;
            end
          endcase
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q == OP_MUL) begin
          acc_d    = alu_f;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
        end
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          if (op_q == OP_MUL) begin
            resp_data_d = alu_f;
          end else if (op_q == OP_DIVU) begin
            resp_data_d = quo_next;
          end else begin
            resp_data_d = rem_next;
          end
        end
      end

      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    resp_data  = resp_data_q;
  end

endmodule
